// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU scheduler: FSM states and ALU opcodes.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_SHL = 3'd7;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 8-bit ALU; carry is bit 8 of a 9-bit evaluation of each operation.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [2:0] opcode_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] out_o,
  output logic       cy_o,
  output logic       zero_o
);

  logic [8:0] a9;
  logic [8:0] b9;
  logic [8:0] res9;

  assign a9 = {1'b0, a_i};
  assign b9 = {1'b0, b_i};

  // Evaluate everything 9 bits wide so NOT sets bit 8 and SHL shifts bit 7 out into the carry
  always_comb begin
    res9 = 9'd0;
    case (opcode_i)
      OP_ADD:  res9 = a9 + b9;
      OP_SUB:  res9 = a9 - b9;
      OP_AND:  res9 = a9 & b9;
      OP_OR:   res9 = a9 | b9;
      OP_XOR:  res9 = a9 ^ b9;
      OP_NOT:  res9 = ~a9;
      OP_SHR:  res9 = a9 >> b_i;
      OP_SHL:  res9 = a9 << b_i;
      default: res9 = 9'd0;
    endcase
  end

  assign out_o  = res9[7:0];
  assign cy_o   = res9[8];
  assign zero_o = (res9[7:0] == 8'd0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin scheduler sharing one ALU between two valid/ready requesters.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_opcode0,
  input  logic [2:0]       req_opcode1,
  input  logic [7:0]       req_a0,
  input  logic [7:0]       req_a1,
  input  logic [7:0]       req_b0,
  input  logic [7:0]       req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_cy,
  output logic             rsp_zero,
  output logic             busy,
  output logic [CNT_W-1:0] op_count0,
  output logic [CNT_W-1:0] op_count1
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic             last_served_q;
  logic             id_q;
  logic [2:0]       opcode_q;
  logic [7:0]       a_q;
  logic [7:0]       b_q;
  logic [7:0]       rsp_result_q;
  logic             rsp_cy_q;
  logic             rsp_zero_q;
  logic [1:0]       rsp_valid_q;
  logic             busy_q;
  logic [CNT_W-1:0] op_count0_q;
  logic [CNT_W-1:0] op_count1_q;

  logic             grant;
  logic             grant_valid;
  logic [2:0]       opcode_d;
  logic [7:0]       a_d;
  logic [7:0]       b_d;
  logic [CNT_W-1:0] op_count0_d;
  logic [CNT_W-1:0] op_count1_d;

  logic [7:0]       alu_out;
  logic             alu_cy;
  logic             alu_zero;

  // Grant only while idle; on a tie the requester not served last time wins
  always_comb begin
    grant       = 1'b0;
    grant_valid = 1'b0;
    if (state_q == ST_IDLE) begin
      case (req_valid)
        2'b01: begin
          grant       = 1'b0;
          grant_valid = 1'b1;
        end
        2'b10: begin
          grant       = 1'b1;
          grant_valid = 1'b1;
        end
        2'b11: begin
          grant       = ~last_served_q;
          grant_valid = 1'b1;
        end
        default: begin
          grant       = 1'b0;
          grant_valid = 1'b0;
        end
      endcase
    end
  end

  assign req_ready = grant_valid ? (2'b01 << grant) : 2'b00;

  // Pick the operand set of the granted requester and precompute the counter increments
  always_comb begin
    opcode_d    = grant ? req_opcode1 : req_opcode0;
    a_d         = grant ? req_a1 : req_a0;
    b_d         = grant ? req_b1 : req_b0;
    op_count0_d = op_count0_q + CNT_ONE;
    op_count1_d = op_count1_q + CNT_ONE;
  end

  alu u_alu (
    .opcode_i (opcode_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .out_o    (alu_out),
    .cy_o     (alu_cy),
    .zero_o   (alu_zero)
  );

  // Accept, execute, hold the response until the owner consumes it; reset discards any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_served_q <= 1'b1;
      id_q          <= 1'b0;
      opcode_q      <= 3'd0;
      a_q           <= 8'd0;
      b_q           <= 8'd0;
      rsp_result_q  <= 8'd0;
      rsp_cy_q      <= 1'b0;
      rsp_zero_q    <= 1'b0;
      rsp_valid_q   <= 2'b00;
      busy_q        <= 1'b0;
      op_count0_q   <= '0;
      op_count1_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            opcode_q <= opcode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= grant;
            busy_q   <= 1'b1;
            state_q  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_result_q <= alu_out;
          rsp_cy_q     <= alu_cy;
          rsp_zero_q   <= alu_zero;
          rsp_valid_q  <= 2'b01 << id_q;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready[id_q]) begin
            last_served_q <= id_q;
            if (id_q) begin
              op_count1_q <= op_count1_d;
            end else begin
              op_count0_q <= op_count0_d;
            end
            rsp_valid_q <= 2'b00;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_cy     = rsp_cy_q;
  assign rsp_zero   = rsp_zero_q;
  assign busy       = busy_q;
  assign op_count0  = op_count0_q;
  assign op_count1  = op_count1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: opcode table, round-robin tie, backpressure, reset mid-response, counter wrap.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [2:0] req_opcode0, req_opcode1;
  logic [7:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0] rsp_ready;

  logic [1:0] req_ready, rsp_valid;
  logic [7:0] rsp_result;
  logic       rsp_cy, rsp_zero, busy;
  logic [7:0] op_count0, op_count1;

  logic [1:0] req_ready_w, rsp_valid_w;
  logic [7:0] rsp_result_w;
  logic       rsp_cy_w, rsp_zero_w, busy_w;
  logic [1:0] op_count0_w, op_count1_w;

  int vecCount  = 0;
  int missCount = 0;
  int cnt0      = 0;
  int cnt1      = 0;

  typedef struct {
    logic       id;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       cy;
    logic       zero;
  } vec_t;

  vec_t vecs[12];

  alu_arbiter #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode0(req_opcode0), .req_opcode1(req_opcode1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cy(rsp_cy), .rsp_zero(rsp_zero),
    .busy(busy), .op_count0(op_count0), .op_count1(op_count1)
  );

  alu_arbiter #(.CNT_W(2)) dutW (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready_w),
    .req_opcode0(req_opcode0), .req_opcode1(req_opcode1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid_w), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result_w), .rsp_cy(rsp_cy_w), .rsp_zero(rsp_zero_w),
    .busy(busy_w), .op_count0(op_count0_w), .op_count1(op_count1_w)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkCounts();
    checkOutput("op_count0", 32'(op_count0), 32'(cnt0 % 256));
    checkOutput("op_count1", 32'(op_count1), 32'(cnt1 % 256));
    checkOutput("op_count0_w", 32'(op_count0_w), 32'(cnt0 % 4));
    checkOutput("op_count1_w", 32'(op_count1_w), 32'(cnt1 % 4));
  endtask

  task automatic applyStimulus(input logic id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    if (id) begin
      req_opcode1 = op;
      req_a1      = a;
      req_b1      = b;
    end else begin
      req_opcode0 = op;
      req_a0      = a;
      req_b0      = b;
    end
  endtask

  task automatic doReset();
    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    step();
    step();
    rst  = 1'b0;
    cnt0 = 0;
    cnt1 = 0;
  endtask

  task automatic runVector(input vec_t v);
    logic [1:0] oneHot;
    oneHot = v.id ? 2'b10 : 2'b01;
    applyStimulus(v.id, v.op, v.a, v.b);
    req_valid = oneHot;
    rsp_ready = 2'b11;
    #1;
    checkOutput("accept req_ready", 32'(req_ready), 32'(oneHot));
    checkOutput("idle busy", 32'(busy), 32'd0);
    step();
    req_valid = 2'b00;
    checkOutput("exec busy", 32'(busy), 32'd1);
    checkOutput("exec req_ready", 32'(req_ready), 32'd0);
    checkOutput("exec rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    checkOutput("resp rsp_valid", 32'(rsp_valid), 32'(oneHot));
    checkOutput("resp result", 32'(rsp_result), 32'(v.res));
    checkOutput("resp cy", 32'(rsp_cy), 32'(v.cy));
    checkOutput("resp zero", 32'(rsp_zero), 32'(v.zero));
    step();
    if (v.id) cnt1++; else cnt0++;
    checkOutput("done rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("done busy", 32'(busy), 32'd0);
    checkCounts();
  endtask

  initial begin
    logic [1:0] wrapSeq[5];
    vec_t       w;

    vecs[0]  = '{id: 1'b0, op: OP_ADD, a: 8'hFF, b: 8'h01, res: 8'h00, cy: 1'b1, zero: 1'b1};
    vecs[1]  = '{id: 1'b1, op: OP_SUB, a: 8'h05, b: 8'h07, res: 8'hFE, cy: 1'b1, zero: 1'b0};
    vecs[2]  = '{id: 1'b0, op: OP_AND, a: 8'hF0, b: 8'h3C, res: 8'h30, cy: 1'b0, zero: 1'b0};
    vecs[3]  = '{id: 1'b1, op: OP_OR,  a: 8'h00, b: 8'h00, res: 8'h00, cy: 1'b0, zero: 1'b1};
    vecs[4]  = '{id: 1'b0, op: OP_XOR, a: 8'hAA, b: 8'h55, res: 8'hFF, cy: 1'b0, zero: 1'b0};
    vecs[5]  = '{id: 1'b1, op: OP_NOT, a: 8'h0F, b: 8'h00, res: 8'hF0, cy: 1'b1, zero: 1'b0};
    vecs[6]  = '{id: 1'b0, op: OP_NOT, a: 8'hFF, b: 8'h00, res: 8'h00, cy: 1'b1, zero: 1'b1};
    vecs[7]  = '{id: 1'b1, op: OP_SHR, a: 8'h80, b: 8'h03, res: 8'h10, cy: 1'b0, zero: 1'b0};
    vecs[8]  = '{id: 1'b0, op: OP_SHL, a: 8'h81, b: 8'h01, res: 8'h02, cy: 1'b1, zero: 1'b0};
    vecs[9]  = '{id: 1'b1, op: OP_ADD, a: 8'h10, b: 8'h20, res: 8'h30, cy: 1'b0, zero: 1'b0};
    vecs[10] = '{id: 1'b0, op: OP_SUB, a: 8'h07, b: 8'h07, res: 8'h00, cy: 1'b0, zero: 1'b1};
    vecs[11] = '{id: 1'b1, op: OP_SHL, a: 8'h01, b: 8'h00, res: 8'h01, cy: 1'b0, zero: 1'b0};
    wrapSeq  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    rst         = 1'b1;
    req_valid   = 2'b00;
    rsp_ready   = 2'b00;
    req_opcode0 = 3'd0;
    req_opcode1 = 3'd0;
    req_a0      = 8'd0;
    req_a1      = 8'd0;
    req_b0      = 8'd0;
    req_b1      = 8'd0;
    step();

    checkOutput("reset req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset result", 32'(rsp_result), 32'd0);
    checkOutput("reset cy", 32'(rsp_cy), 32'd0);
    checkOutput("reset zero", 32'(rsp_zero), 32'd0);
    checkCounts();
    step();
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      runVector(vecs[i]);
    end

    $display("[TB] tie and fairness");
    doReset();
    applyStimulus(1'b0, OP_XOR, 8'hAA, 8'hAA);
    applyStimulus(1'b1, OP_SHL, 8'h81, 8'h01);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    for (int g = 0; g < 4; g++) begin
      checkOutput("tie grant", 32'(req_ready), (g % 2 == 0) ? 32'd1 : 32'd2);
      step();
      checkOutput("tie exec req_ready", 32'(req_ready), 32'd0);
      step();
      checkOutput("tie rsp_valid", 32'(rsp_valid), (g % 2 == 0) ? 32'd1 : 32'd2);
      checkOutput("tie result", 32'(rsp_result), (g % 2 == 0) ? 32'h00 : 32'h02);
      checkOutput("tie cy", 32'(rsp_cy), (g % 2 == 0) ? 32'd0 : 32'd1);
      checkOutput("tie zero", 32'(rsp_zero), (g % 2 == 0) ? 32'd1 : 32'd0);
      step();
      if (g % 2 == 0) cnt0++; else cnt1++;
    end
    req_valid = 2'b00;
    checkCounts();

    $display("[TB] backpressure");
    applyStimulus(1'b0, OP_ADD, 8'h01, 8'h02);
    applyStimulus(1'b1, OP_OR, 8'h0F, 8'hF0);
    req_valid = 2'b11;
    rsp_ready = 2'b10;
    #1;
    checkOutput("bp grant", 32'(req_ready), 32'd1);
    step();
    req_valid = 2'b10;
    step();
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp result", 32'(rsp_result), 32'h03);
      checkOutput("bp busy", 32'(busy), 32'd1);
      checkOutput("bp req_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 2'b11;
    #1;
    checkOutput("bp release rsp_valid", 32'(rsp_valid), 32'd1);
    step();
    cnt0++;
    checkOutput("bp late grant", 32'(req_ready), 32'd2);
    checkCounts();
    step();
    req_valid = 2'b00;
    step();
    checkOutput("bp r1 rsp_valid", 32'(rsp_valid), 32'd2);
    checkOutput("bp r1 result", 32'(rsp_result), 32'hFF);
    checkOutput("bp r1 cy", 32'(rsp_cy), 32'd0);
    step();
    cnt1++;
    checkCounts();

    $display("[TB] reset in response");
    applyStimulus(1'b0, OP_ADD, 8'h11, 8'h22);
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    step();
    req_valid = 2'b00;
    step();
    checkOutput("rr rsp_valid before", 32'(rsp_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    cnt0 = 0;
    cnt1 = 0;
    checkOutput("rr rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rr busy", 32'(busy), 32'd0);
    checkCounts();
    @(negedge clk);
    rst = 1'b0;
    step();
    applyStimulus(1'b0, OP_SUB, 8'h09, 8'h04);
    applyStimulus(1'b1, OP_AND, 8'hFF, 8'h0F);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    checkOutput("rr tie grant", 32'(req_ready), 32'd1);
    step();
    req_valid = 2'b00;
    step();
    checkOutput("rr result", 32'(rsp_result), 32'h05);
    step();
    cnt0++;
    checkCounts();

    $display("[TB] counter wrap");
    doReset();
    w = '{id: 1'b1, op: OP_ADD, a: 8'h01, b: 8'h01, res: 8'h02, cy: 1'b0, zero: 1'b0};
    for (int k = 0; k < 5; k++) begin
      runVector(w);
      checkOutput("wrap op_count1_w", 32'(op_count1_w), 32'(wrapSeq[k]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
